// File: rtl/mul_pkg.sv
// Shared constants for the memory-mapped iterative multiplier: register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package mul_pkg;

    localparam int unsigned MulWidth = 32;

    localparam logic [2:0] RegOpa   = 3'd0;
    localparam logic [2:0] RegOpb   = 3'd1;
    localparam logic [2:0] RegCtrl  = 3'd2;
    localparam logic [2:0] RegStat  = 3'd3;
    localparam logic [2:0] RegResLo = 3'd4;
    localparam logic [2:0] RegResHi = 3'd5;

    localparam int unsigned CtrlStartBit  = 0;
    localparam int unsigned CtrlSignedBit = 1;
    localparam int unsigned CtrlClearBit  = 2;

    localparam int unsigned StatBusyBit   = 0;
    localparam int unsigned StatDoneBit   = 1;
    localparam int unsigned StatSignedBit = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add multiplier on operand magnitudes, with a final sign fix.
// Holds the published product so it only ever changes as a whole.
module mul_shift_add_core
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MulWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic                 clear_done_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sign_mode_o,
    output logic [2*WIDTH-1:0]   result_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e               state_q;
    logic [CntW-1:0]      cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic                 neg_q;
    logic                 sign_mode_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   res_q;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;

    always_comb begin
        mag_a = (signed_i && opa_i[WIDTH-1]) ? (~opa_i + 1'b1) : opa_i;
        mag_b = (signed_i && opb_i[WIDTH-1]) ? (~opb_i + 1'b1) : opb_i;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
        // Carry out of the upper-half add becomes the new MSB after the shift.
        acc_step = acc_q[0] ? {sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            sign_mode_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mcand_q     <= mag_a;
                        acc_q       <= {{WIDTH{1'b0}}, mag_b};
                        neg_q       <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                        sign_mode_q <= signed_i;
                        cnt_q       <= CntW'(WIDTH);
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        state_q     <= StRun;
                    end else if (clear_done_i) begin
                        done_q <= 1'b0;
                    end
                end
                StRun: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    res_q   <= neg_q ? (~acc_q + 1'b1) : acc_q;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign sign_mode_o = sign_mode_q;
    assign result_o    = res_q;

endmodule

// File: rtl/mul_periph.sv
// Bus-facing multiplier peripheral: operand registers, CTRL decode and the
// combinational read mux in front of the shift-add core.
module mul_periph
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = MulWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic               wr_en;
    logic               ctrl_wr;
    logic               start;
    logic               clear_done;
    logic               sign_mode;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   status;

    assign wr_en      = ce & we;
    assign ctrl_wr    = wr_en & (addr == RegCtrl);
    assign start      = ctrl_wr & wdata[CtrlStartBit];
    assign clear_done = ctrl_wr & wdata[CtrlClearBit];

    // Operands stay writable while busy; the core works from its own snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opa_q <= '0;
            opb_q <= '0;
        end else if (wr_en) begin
            if (addr == RegOpa) opa_q <= wdata;
            if (addr == RegOpb) opb_q <= wdata;
        end
    end

    mul_shift_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i       (clk),
        .rst_ni      (reset),
        .start_i     (start),
        .signed_i    (wdata[CtrlSignedBit]),
        .clear_done_i(clear_done),
        .opa_i       (opa_q),
        .opb_i       (opb_q),
        .busy_o      (busy),
        .done_o      (done),
        .sign_mode_o (sign_mode),
        .result_o    (result)
    );

    always_comb begin
        status                = '0;
        status[StatBusyBit]   = busy;
        status[StatDoneBit]   = done;
        status[StatSignedBit] = sign_mode;
    end

    always_comb begin
        rdata = '0;
        if (ce) begin
            case (addr)
                RegOpa:   rdata = opa_q;
                RegOpb:   rdata = opb_q;
                RegStat:  rdata = status;
                RegResLo: rdata = result[WIDTH-1:0];
                RegResHi: rdata = result[2*WIDTH-1:WIDTH];
                default:  rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/mul_periph.md
Name: mul_periph

Overview:
- Memory-mapped iterative multiplier peripheral and responder on the CPU data bus, alongside dmem and accumulator.
- The CPU writes two 32-bit operands, sets a start bit, polls status, then reads a 64-bit product.
- The top level decodes its address window through the arbiter: ce = arbiter enable, we = (we != 0), addr = daddr[4:2], clock = ~man_clk as for the other slaves.
- Radix-2 shift-add datapath, one product bit per cycle, signed or unsigned.

Parameters:
WIDTH, 32, operand width; must equal the data bus width; only 32 is supported.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
ce  input  1  block select from arbiter; writes need ce=1
we  input  1  write strobe; write occurs when ce&we at the clk edge
addr  input  3  word index (daddr[4:2])
wdata  input  32  write data
rdata  output  32  read data, combinational from addr and registers; 0 when ce=0
busy  output  1  operation in progress (mirror of STATUS[0])
done  output  1  result valid (mirror of STATUS[1])

Behaviour:
- Register map by addr:
  - 0 OPA (RW)
  - 1 OPB (RW)
  - 2 CTRL: write-only, reads 0. bit0 = start, bit1 = signed, bit2 = clear_done.
  - 3 STATUS (RO): bit0 = busy, bit1 = done, bit2 = signed mode of last op, other bits 0.
  - 4 RES_LO (RO)
  - 5 RES_HI (RO)
  - 6, 7 read 0.
  - Writes to RO or unused addresses are ignored.
- Reset: OPA, OPB, RES_LO, RES_HI, signed flag, counter, busy and done all 0; state IDLE; rdata is 0 whenever ce=0.
- States:
  - IDLE: a CTRL write with start=1 snapshots |OPA| and |OPB| (two's-complement magnitude if signed=1, raw if 0) and the result sign (OPA[31]^OPB[31] when signed). Clears the accumulator, loads counter=WIDTH, sets busy=1 and done=0, goes to RUN.
  - RUN: each cycle, if multiplier LSB=1 add the multiplicand into the upper half of the 64-bit accumulator (33-bit sum, carry kept), then shift the accumulator right by 1 and decrement the counter. After the cycle where counter==1, go to FIX.
  - FIX: negate the 64-bit product if the sign flag is set, write RES_HI:RES_LO, set busy=0 and done=1, go to IDLE.
- Latency: start written at edge E0 gives RUN on E1..E32, FIX on E33; STATUS reads done=1 from just after E33, i.e. WIDTH+1 cycles after the start edge.
- RES_LO/RES_HI hold the previous result until FIX; they are never partially updated.
- Start while busy: ignored; the current operation is unaffected.
- OPA/OPB written while busy: the registers update, but the running operation uses its snapshot.
- clear_done=1: clears done in IDLE; ignored while busy.
- start=1 and clear_done=1 in the same write: start wins, and done=0 as a result.
- Magnitude of 0x8000_0000 is 2^31, which fits in 32 unsigned bits; no overflow case exists. The signed product of two -2^31 operands is +2^62.
- Reset asserted mid-operation: immediate return to IDLE with all registers cleared; no result is written.

Decomposition:
- Package mul_pkg:
  - register offset constants (OPA=0 … RES_HI=5)
  - CTRL/STATUS bit positions
  - state enum {IDLE, RUN, FIX}
  - WIDTH default
- One sub-module mul_shift_add_core: magnitude datapath, 64-bit accumulator, counter and sign fix, with start/busy/done handshake.
- Top-level mul_periph keeps register decode, read mux and operand registers.

Test Plan:
- Unsigned: OPA=7, OPB=6, start (CTRL=0x1) → busy=1 after next edge; done=1 exactly 33 cycles after the start edge; RES_LO=42, RES_HI=0.
- Unsigned max: 0xFFFF_FFFF × 0xFFFF_FFFF → RES_HI=0xFFFF_FFFE, RES_LO=0x0000_0001.
- Signed (CTRL=0x3):
  - -3 × 5 → RES_HI=0xFFFF_FFFF, RES_LO=0xFFFF_FFF1, STATUS[2]=1.
  - 0x8000_0000 × 0x8000_0000 → RES_HI=0x4000_0000, RES_LO=0.
- Start while busy: start 2×3, then at cycle 10 write OPA=9 and CTRL=0x1 → result still 6 at cycle 33; OPA reads 9; no second operation runs (busy=0 after done).
- done clear and ce gating:
  - Write CTRL=0x4 after completion → done=0, result registers retained.
  - Reads with ce=0 return 0.
  - Writes with ce=0 do not change OPA.
- Reset mid-operation: assert reset=0 at cycle 15 of RUN → busy=0, done=0, RES_LO/RES_HI=0 immediately, without waiting for a clock edge; a subsequent 4×4 start yields 16.
